// File: rtl/egg_countdown.sv
// BCD MM:SS countdown driven by the egg-timer controller's run level and 1 Hz toggle.
// Optional ALARM_BEEP_EN: pulse the alarm output at the sec_clk rate instead of a steady level.
module egg_countdown #(
  parameter int unsigned ALARM_TICKS  = 10,
  parameter int unsigned MAX_MIN_TENS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_counting,
  input  logic        sec_clk,
  input  logic        load,
  input  logic [15:0] preset,
  output logic [15:0] digits,
  output logic        running,
  output logic        done,
  output logic        alarm
);

  localparam int unsigned DW = 4;
  localparam int unsigned TW = 4 * DW;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   digits_q, digits_d;
  logic            alarm_q, alarm_d;
  logic [CW-1:0]   alarm_cnt_q, alarm_cnt_d;
  logic            sec_clk_q;
  logic            tick_c;
  logic [TW-1:0]   dec_c;

  // Saturate each preset digit to its legal BCD range.
  function automatic logic [TW-1:0] clamp_preset(input logic [TW-1:0] p);
    logic [DW-1:0] m1, m0, s1, s0;
    m1 = p[15:12];
    m0 = p[11:8];
    s1 = p[7:4];
    s0 = p[3:0];
    if (m1 > DW'(9))            m1 = DW'(9);
    if (m1 > DW'(MAX_MIN_TENS)) m1 = DW'(MAX_MIN_TENS);
    if (m0 > DW'(9))            m0 = DW'(9);
    if (s1 > DW'(5))            s1 = DW'(5);
    if (s0 > DW'(9))            s0 = DW'(9);
    return {m1, m0, s1, s0};
  endfunction

  // One-second BCD decrement; each digit wraps and borrows from the next.
  function automatic logic [TW-1:0] bcd_dec(input logic [TW-1:0] t);
    logic [DW-1:0] m1, m0, s1, s0;
    m1 = t[15:12];
    m0 = t[11:8];
    s1 = t[7:4];
    s0 = t[3:0];
    if (s0 != '0) begin
      s0 = s0 - DW'(1);
    end else begin
      s0 = DW'(9);
      if (s1 != '0) begin
        s1 = s1 - DW'(1);
      end else begin
        s1 = DW'(5);
        if (m0 != '0) begin
          m0 = m0 - DW'(1);
        end else begin
          m0 = DW'(9);
          m1 = m1 - DW'(1);
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  assign tick_c = sec_clk & ~sec_clk_q;
  assign dec_c  = bcd_dec(digits_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      digits_q    <= '0;
      alarm_q     <= 1'b0;
      alarm_cnt_q <= '0;
      sec_clk_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      digits_q    <= digits_d;
      alarm_q     <= alarm_d;
      alarm_cnt_q <= alarm_cnt_d;
      sec_clk_q   <= sec_clk;
    end
  end

  always_comb begin
    state_d     = state_q;
    digits_d    = digits_q;
    alarm_d     = alarm_q;
    alarm_cnt_d = alarm_cnt_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          digits_d = clamp_preset(preset);
        end else if (is_counting) begin
          if (digits_q != '0) begin
            state_d = RUN;
          end else begin
            state_d     = DONE;
            alarm_d     = 1'b1;
            alarm_cnt_d = '0;
          end
        end
      end
      RUN: begin
        // Losing the run level wins over a coincident tick.
        if (!is_counting) begin
          state_d = IDLE;
        end else if (tick_c) begin
          digits_d = dec_c;
          if (dec_c == '0) begin
            state_d     = DONE;
            alarm_d     = 1'b1;
            alarm_cnt_d = '0;
          end
        end
      end
      DONE: begin
        if (!is_counting) begin
          state_d = IDLE;
          alarm_d = 1'b0;
        end else if (tick_c && alarm_q) begin
          alarm_cnt_d = alarm_cnt_q + CW'(1);
          if (alarm_cnt_q == CW'(ALARM_TICKS - 1)) alarm_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign digits  = digits_q;
  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);

`ifdef ALARM_BEEP_EN
  assign alarm = alarm_q & sec_clk_q;
`else
  assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_egg_countdown.sv
// Directed bench for egg_countdown: borrow chain, expiry/alarm window, clamping, abort, reset.
`timescale 1ns/1ps
module tb_egg_countdown;

  logic        clk;
  logic        rst;
  logic        is_counting;
  logic        sec_clk;
  logic        load;
  logic [15:0] preset;
  logic [15:0] digits;
  logic        running;
  logic        done;
  logic        alarm;

  int n_checks = 0;
  int n_fail   = 0;

  egg_countdown #(.ALARM_TICKS(10), .MAX_MIN_TENS(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .is_counting (is_counting),
    .sec_clk     (sec_clk),
    .load        (load),
    .preset      (preset),
    .digits      (digits),
    .running     (running),
    .done        (done),
    .alarm       (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Alarm as seen on the port, given the alarm level and the registered sec_clk phase.
  function automatic logic exp_alarm(input logic lvl, input logic phase_hi);
`ifdef ALARM_BEEP_EN
    return lvl & phase_hi;
`else
    return lvl | (phase_hi & 1'b0);
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sec_rise();
    cyc();
    sec_clk = 1'b1;
    cyc();
  endtask

  task automatic sec_fall();
    sec_clk = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic sec_edges(input int n);
    for (int i = 0; i < n; i++) begin
      sec_rise();
      sec_fall();
    end
  endtask

  task automatic do_load(input logic [15:0] p);
    cyc();
    load   = 1'b1;
    preset = p;
    cyc();
    load   = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    is_counting = 1'b0;
    sec_clk     = 1'b0;
    load        = 1'b0;
    preset      = 16'h0000;
    #23;
    check("rst_digits",  digits, 16'h0000);
    check("rst_running", 16'(running), 16'd0);
    check("rst_done",    16'(done), 16'd0);
    check("rst_alarm",   16'(alarm), 16'd0);
    @(negedge clk);
    rst = 1'b1;

    // Full borrow chain from 10:00.
    do_load(16'h1000);
    is_counting = 1'b1;
    cyc();
    check("run_enter", 16'(running), 16'd1);
    sec_edges(1);
    check("borrow_chain", digits, 16'h0959);
    sec_edges(59);
    check("after_60s", digits, 16'h0900);
    check("still_run", 16'(running), 16'd1);

    // Expiry from 00:03 and the alarm window.
    is_counting = 1'b0;
    cyc();
    check("hold_idle", digits, 16'h0900);
    do_load(16'h0003);
    is_counting = 1'b1;
    cyc();
    sec_edges(2);
    check("pre_expiry", digits, 16'h0001);
    sec_rise();
    check("expiry_digits", digits, 16'h0000);
    check("expiry_done",   16'(done), 16'd1);
    check("expiry_run",    16'(running), 16'd0);
    check("expiry_alarm_hi", 16'(alarm), 16'(exp_alarm(1'b1, 1'b1)));
    sec_fall();
    check("expiry_alarm_lo", 16'(alarm), 16'(exp_alarm(1'b1, 1'b0)));
    sec_edges(8);
    sec_rise();
    check("alarm_tick9_hi", 16'(alarm), 16'(exp_alarm(1'b1, 1'b1)));
    sec_fall();
    check("alarm_tick9_lo", 16'(alarm), 16'(exp_alarm(1'b1, 1'b0)));
    sec_rise();
    check("alarm_tick10", 16'(alarm), 16'd0);
    check("done_hold",    16'(done), 16'd1);
    sec_fall();
    sec_edges(1);
    check("alarm_after", 16'(alarm), 16'd0);
    check("done_digits", digits, 16'h0000);

    // Leave DONE, then clamped load with is_counting already high.
    is_counting = 1'b0;
    cyc();
    check("done_exit", 16'(done), 16'd0);
    is_counting = 1'b1;
    load        = 1'b1;
    preset      = 16'hFA7C;
    cyc();
    load = 1'b0;
    check("clamp_digits",  digits, 16'h5959);
    check("load_priority", 16'(running), 16'd0);
    check("load_no_done",  16'(done), 16'd0);
    cyc();
    check("run_after_load", 16'(running), 16'd1);

    // Abort mid-run with a coincident tick, then zero-start.
    is_counting = 1'b0;
    cyc();
    do_load(16'h0045);
    is_counting = 1'b1;
    cyc();
    sec_edges(3);
    check("run_0042", digits, 16'h0042);
    cyc();
    is_counting = 1'b0;
    sec_clk     = 1'b1;
    cyc();
    check("abort_running", 16'(running), 16'd0);
    check("abort_digits",  digits, 16'h0042);
    sec_fall();
    sec_edges(2);
    check("idle_ticks_ignored", digits, 16'h0042);
    do_load(16'h0000);
    is_counting = 1'b1;
    cyc();
    check("zero_start_done",   16'(done), 16'd1);
    check("zero_start_digits", digits, 16'h0000);
    check("zero_start_alarm",  16'(alarm), 16'(exp_alarm(1'b1, 1'b0)));

    // Asynchronous reset while alarming in DONE.
    @(posedge clk);
    #2;
    rst         = 1'b0;
    is_counting = 1'b0;
    #1;
    check("rst_done_done",  16'(done), 16'd0);
    check("rst_done_alarm", 16'(alarm), 16'd0);
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset mid-run.
    do_load(16'h0130);
    is_counting = 1'b1;
    cyc();
    sec_edges(1);
    check("run_0129", digits, 16'h0129);
    @(posedge clk);
    #2;
    rst         = 1'b0;
    is_counting = 1'b0;
    #1;
    check("rst_run_digits",  digits, 16'h0000);
    check("rst_run_running", 16'(running), 16'd0);
    check("rst_run_done",    16'(done), 16'd0);
    check("rst_run_alarm",   16'(alarm), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    check("post_rst_idle", 16'(running), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/egg_countdown.md
Name: egg_countdown

Overview:
Downstream consumer of the egg-timer controller FSM. Takes the controller's is_counting level and its sec_clk toggle, and decrements a BCD MM:SS time once per sec_clk rising edge. Drives done/alarm outputs when the count reaches 00:00. Its BCD digits feed the seven-segment display driver.

Parameters:
ALARM_TICKS, 10, number of sec_clk rising edges the alarm stays asserted after expiry (legal 1..255)
MAX_MIN_TENS, 5, largest accepted minutes-tens digit on load; larger values clamp to this

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low (0 = reset)
is_counting  input  1  run enable from controller FSM (level)
sec_clk  input  1  square wave from controller FSM; each rising edge is one second
load  input  1  single-cycle pulse: capture preset digits
preset  input  16  BCD preset {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each
digits  output  16  current BCD time, same packing as preset
running  output  1  high in RUN
done  output  1  high in DONE
alarm  output  1  alarm drive, high for ALARM_TICKS seconds after expiry

Behaviour:
- Reset (rst=0, async): state=IDLE, digits=16'h0000, alarm=0, running=0, done=0, sec_clk_d=0, alarm_cnt=0.
- Tick detect: sec_clk_d is sec_clk registered once; tick = sec_clk & ~sec_clk_d. One tick per sec_clk rising edge. A tick acts only in RUN and DONE; ticks in IDLE are ignored.
- States: IDLE=2'd0, RUN=2'd1, DONE=2'd2. 2'd3 is unreachable and recovers to IDLE on the next clock.
- IDLE:
  - load=1: digits <= clamped preset.
    - Any digit >9 clamps to 9.
    - sec_tens >5 clamps to 5.
    - min_tens >MAX_MIN_TENS clamps to MAX_MIN_TENS.
  - load has priority. The state does not change in a cycle where load=1.
  - load=0, is_counting=1, digits!=0 -> RUN next cycle.
  - load=0, is_counting=1, digits==0 -> DONE next cycle; alarm=1, alarm_cnt=0.
- RUN:
  - On tick, BCD decrement with a borrow chain. Example: 10:00 -> 09:59.
    - sec_ones 0 -> 9, borrow.
    - sec_tens 0 -> 5, borrow.
    - min_ones 0 -> 9, borrow.
    - min_tens decrements.
  - If the decrement result is 0000: state <= DONE, alarm <= 1, alarm_cnt <= 0, all on the same clock edge.
  - load is ignored in RUN.
  - is_counting=0 (controller was reset) -> IDLE next cycle. digits hold their value. A tick arriving in that same cycle is not applied.
- DONE:
  - digits stay 0000. load is ignored.
  - On each tick while alarm=1: alarm_cnt++. When alarm_cnt reaches ALARM_TICKS-1 on a tick, alarm <= 0.
  - is_counting=0 -> IDLE next cycle and alarm <= 0, regardless of alarm_cnt.
- Outputs are registered or pure state decodes: running=(state==RUN), done=(state==DONE). digits reflect the register directly.
- Latency: a sec_clk rising edge is sampled by clk at cycle N, so tick=1 at cycle N. digits update on the edge ending cycle N. Worst case is 2 clk after the sec_clk edge.
- Widths: alarm_cnt is 8 bits. No other arithmetic wider than 4-bit BCD digits.
- Reset mid-RUN: everything clears immediately, no alarm.

Optional Feature:
Macro ALARM_BEEP_EN.
- Defined: while alarm is active, the alarm port carries alarm & sec_clk_d, giving a pulsed beep at the sec_clk rate. The alarm duration is unchanged.
- Undefined: the alarm port is a steady level for the full ALARM_TICKS seconds.
- With the macro undefined, no extra logic is synthesised.

Test Plan:
1. Reset values: assert rst=0 mid-simulation -> digits=0000, running=0, done=0, alarm=0, checked asynchronously before the next clk edge.
2. Borrow chain: load preset=16'h1000, set is_counting=1, apply 1 sec_clk edge -> digits=16'h0959. Apply 59 more edges -> 16'h0900.
3. Expiry: load 16'h0003, run, apply 3 edges -> digits=0000, done=1, alarm=1 on the 3rd tick edge. After 10 more edges -> alarm=0, done still 1.
4. Clamp and priority: in IDLE with is_counting=1, pulse load with preset=16'hFA7C -> digits=16'h5959 and state stays IDLE that cycle. running=1 on the following cycle.
5. Abort and zero-start: mid-RUN at 16'h0042, drop is_counting -> IDLE with digits holding 0042, and later ticks do not change it. Then load 0000 with is_counting=1 -> done=1 next cycle, digits stay 0000.
6. ALARM_BEEP_EN build: repeat scenario 3 -> alarm follows sec_clk_d during the 10-second window and is 0 afterwards.
